gate_truth_table_checker: RTL
=============================

GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, legal 1..15: cycles each input vector is held before the outputs are sampled.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a full truth-table sweep.
REQ-005 abort  input  1  terminates a sweep in progress.
REQ-006 drv_a  output  1  operand a driven to the gate block under test.
REQ-007 drv_b  output  1  operand b driven to the gate block under test.
REQ-008 gate_y  input  5  gate block outputs: bit0=AND, bit1=NAND, bit2=OR, bit3=NOR, bit4=XOR.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 pass  output  1  1 when the last completed sweep had no mismatches.
REQ-012 fail_mask  output  5  per-gate sticky mismatch flags, same bit order as gate_y.
REQ-013 first_fail_vec  output  2  vector index {a,b} of the first mismatch.
REQ-014 first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-015 States SHALL be IDLE, DRIVE, SAMPLE and DONE.
REQ-016 IDLE, start=1 SHALL clear fail_mask, first_fail_valid and pass, set vector index 0 and settle counter 0, and go to DRIVE.
REQ-017 start while busy SHALL be ignored.
REQ-018 drv_a=index[1] and drv_b=index[0] SHALL be registered and constant throughout DRIVE and SAMPLE of each vector.
REQ-019 DRIVE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-020 SAMPLE SHALL last one cycle and compare gate_y against the expected values {a^b, ~(a|b), a|b, ~(a&b), a&b}, listed from bit4 down to bit0.
REQ-021 Each mismatching bit SHALL set the corresponding fail_mask bit (OR-accumulate).
REQ-022 The first SAMPLE with any mismatch SHALL load first_fail_vec with the index and set first_fail_valid; later mismatches SHALL NOT overwrite it.
REQ-023 After SAMPLE, index<3 SHALL increment the index and return to DRIVE; index=3 SHALL go to DONE.
REQ-024 DONE SHALL last one cycle with done=1 and pass=(updated fail_mask==0), then go to IDLE.
REQ-025 pass SHALL hold its value until the next accepted start or reset.
REQ-026 done SHALL rise exactly 4*(SETTLE_CYCLES+1) cycles after the edge that accepts start.
REQ-027 busy SHALL be 1 in DRIVE, SAMPLE and DONE, and 0 in IDLE.
REQ-028 abort in DRIVE or SAMPLE SHALL go to IDLE next edge without a done pulse, with pass=0 and drv_a=drv_b=0; fail_mask and first_fail SHALL retain their values.
REQ-029 abort SHALL have priority over a same-cycle SAMPLE compare, which is then discarded.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 start and abort together in IDLE SHALL start a sweep.

Reset
REQ-032 rst=1 SHALL force IDLE and drive drv_a, drv_b, busy, done, pass, fail_mask, first_fail_vec and first_fail_valid all to 0, regardless of state.
REQ-033 rst SHALL have priority over start and abort.

Structure
REQ-034 A shared package SHALL hold the state enum, the gate bit-index constants (AND=0 .. XOR=4), NUM_GATES=5 and NUM_VECTORS=4.
REQ-035 Expected-value generation SHALL be one combinational sub-module, gate_expect (a, b in; 5-bit expected out), instantiated once.
REQ-036 The settle counter SHALL be 4 bits wide.

Verification
REQ-037 Correct gate block connected, SETTLE_CYCLES=2, start pulse -> drive vectors 00,01,10,11; done 12 cycles after start; pass=1; fail_mask=00000; first_fail_valid=0.
REQ-038 gate_y[4] forced to 0 -> first mismatch at vector 01; done, pass=0, fail_mask=10000, first_fail_vec=01, first_fail_valid=1.
REQ-039 gate_y[0] stuck at 1 -> fail_mask=00001, first_fail_vec=00.
REQ-040 abort asserted on the SAMPLE cycle of vector 2 while gate_y[2] mismatches -> IDLE next cycle, no done pulse, fail_mask excludes bit2, pass=0.
REQ-041 start re-pulsed mid-sweep -> no effect on sequence or timing.
REQ-042 rst asserted mid-DRIVE -> all outputs 0 next cycle; a following start runs a full clean sweep.

Source files
------------

// File: rtl/gate_truth_table_checker_pkg.sv
// rtl/gate_truth_table_checker_pkg.sv - shared types and constants for the gate truth-table checker
package gate_truth_table_checker_pkg;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit positions of each gate inside gate_y / fail_mask
  localparam int GATE_AND  = 0;
  localparam int GATE_NAND = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XOR  = 4;

  localparam int NUM_GATES   = 5;
  localparam int NUM_VECTORS = 4;

  // Vector index is {a,b}; settle counter covers SETTLE_CYCLES up to 15
  localparam int VEC_W = 2;
  localparam int CNT_W = 4;

  // Last vector index of a sweep
  function automatic logic [VEC_W-1:0] last_vector();
    return VEC_W'(NUM_VECTORS - 1);
  endfunction

endpackage

// File: rtl/gate_expect.sv
// rtl/gate_expect.sv - golden two-input gate outputs for one operand pair
module gate_expect
  import gate_truth_table_checker_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] y
);

  // Reference value of every gate in the same bit order as gate_y
  always_comb begin
    y            = '0;
    y[GATE_AND]  = a & b;
    y[GATE_NAND] = ~(a & b);
    y[GATE_OR]   = a | b;
    y[GATE_NOR]  = ~(a | b);
    y[GATE_XOR]  = a ^ b;
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - sweeps all operand pairs through a gate block and flags mismatches
module gate_truth_table_checker
  import gate_truth_table_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 drv_a,
  output logic                 drv_b,
  input  logic [NUM_GATES-1:0] gate_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [VEC_W-1:0]     first_fail_vec,
  output logic                 first_fail_valid
);

  // Counter value on the final DRIVE cycle of a vector
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [VEC_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drv_a_q, drv_a_d;
  logic                 drv_b_q, drv_b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
  logic [VEC_W-1:0]     first_fail_vec_q, first_fail_vec_d;
  logic                 first_fail_valid_q, first_fail_valid_d;

  logic [NUM_GATES-1:0] expect_y;
  logic [NUM_GATES-1:0] mismatch;
  logic [NUM_GATES-1:0] merged_mask;
  logic [VEC_W-1:0]     idx_next;

  // Expected outputs follow the registered operands, so they are stable during SAMPLE
  gate_expect u_expect (
    .a (drv_a_q),
    .b (drv_b_q),
    .y (expect_y)
  );

  // Next-state and next-output computation for the sweep sequencer
  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    cnt_d              = cnt_q;
    drv_a_d            = drv_a_q;
    drv_b_d            = drv_b_q;
    done_d             = 1'b0;
    pass_d             = pass_q;
    fail_mask_d        = fail_mask_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;

    mismatch    = gate_y ^ expect_y;
    merged_mask = fail_mask_q | mismatch;
    idx_next    = idx_q + VEC_W'(1);

    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here; start alone decides
        if (start) begin
          state_d            = ST_DRIVE;
          idx_d              = '0;
          cnt_d              = '0;
          drv_a_d            = 1'b0;
          drv_b_d            = 1'b0;
          fail_mask_d        = '0;
          first_fail_valid_d = 1'b0;
          pass_d             = 1'b0;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
          drv_a_d = 1'b0;
          drv_b_d = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // The compare of this cycle is dropped on the floor
          state_d = ST_IDLE;
          pass_d  = 1'b0;
          drv_a_d = 1'b0;
          drv_b_d = 1'b0;
        end else begin
          fail_mask_d = merged_mask;
          if ((|mismatch) && !first_fail_valid_q) begin
            first_fail_vec_d   = idx_q;
            first_fail_valid_d = 1'b1;
          end
          if (idx_q == last_vector()) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (merged_mask == '0);
          end else begin
            state_d = ST_DRIVE;
            idx_d   = idx_next;
            cnt_d   = '0;
            drv_a_d = idx_next[1];
            drv_b_d = idx_next[0];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        drv_a_d = 1'b0;
        drv_b_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      idx_q              <= '0;
      cnt_q              <= '0;
      drv_a_q            <= 1'b0;
      drv_b_q            <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      fail_mask_q        <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      cnt_q              <= cnt_d;
      drv_a_q            <= drv_a_d;
      drv_b_q            <= drv_b_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      fail_mask_q        <= fail_mask_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign drv_a            = drv_a_q;
  assign drv_b            = drv_b_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_mask        = fail_mask_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule
